// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares one AXI4-Lite-style DRAM port between two internal requesters.
//   Each requester issues single-beat 64-bit reads or writes. A round-robin
//   pick selects one, the full AR/R or AW/W/B handshake runs against DRAM,
//   and completion (plus read data) goes back to the winner. Only one DRAM
//   transaction is outstanding at any time.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   req[1:0], we[1:0]      per-requester request and write flag
//   addr0/addr1            per-requester byte address
//   wdata0/wdata1          per-requester write data
//   done[1:0], err, rdata  completion pulse, error flag, read data
//   AR_*, R_*, AW_*, W_*, B_*  DRAM bus channels
//   dbgState               current FSM state (debug visibility)
//
// Handshake rule: a channel transfers on a rising edge where its VALID and
// READY are both high. This block holds each VALID/READY it drives until
// that transfer happens; there is no timeout. All bus outputs are decoded
// from the state register alone, so they never depend combinationally on
// DRAM inputs.

module dram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY,
  output logic [2:0]        dbgState
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;
  localparam logic [2:0] S_RESP = 3'd6;

  logic [2:0]        state;
  logic              last;      // most recently granted requester
  logic              grant;     // requester owning the current transaction
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic              errBit;

  // Round-robin pick: with both requesting, the one not granted last wins;
  // otherwise whichever single requester is active.
  logic              pick;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else              pick = req[1];
    selWe    = pick ? we[1]  : we[0];
    selAddr  = pick ? addr1  : addr0;
    selWdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last     <= 1'b1;   // so requester 0 wins the first contested grant
      grant    <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      errBit   <= 1'b0;
      rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant    <= pick;
            last     <= pick;
            addrReg  <= selAddr;
            wdataReg <= selWdata;
            if (selAddr[2:0] != 3'b000) begin
              // Misaligned: complete with error, never touch the bus.
              errBit <= 1'b1;
              state  <= S_RESP;
            end else begin
              errBit <= 1'b0;
              state  <= selWe ? S_AW : S_AR;
            end
          end
        end
        S_AR: if (AR_READY) state <= S_R;
        S_R: begin
          if (R_VALID) begin
            rdata  <= R_DATA;
            errBit <= (R_RESP != 2'b00);
            state  <= S_RESP;
          end
        end
        S_AW: if (AW_READY) state <= S_W;
        S_W:  if (W_READY)  state <= S_B;
        S_B: begin
          if (B_VALID) begin
            errBit <= (B_RESP != 2'b00);
            state  <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode; address/data are zeroed whenever their VALID is low.
  always_comb begin
    AR_VALID = (state == S_AR);
    AR_ADDR  = AR_VALID ? addrReg : '0;
    R_READY  = (state == S_R);
    AW_VALID = (state == S_AW);
    AW_ADDR  = AW_VALID ? addrReg : '0;
    W_VALID  = (state == S_W);
    W_DATA   = W_VALID ? wdataReg : '0;
    B_READY  = (state == S_B);
    done     = 2'b00;
    if (state == S_RESP) done = grant ? 2'b10 : 2'b01;
    err      = (state == S_RESP) && errBit;
    dbgState = state;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Directed bench for dram_arbiter: a small DRAM responder with programmable
//   per-channel wait states, a transaction helper that waits (bounded) for a
//   done pulse while recording bus activity, and a single check task.

module tb_dram_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]        req = 2'b00;
  logic [1:0]        we = 2'b00;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]        done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              AR_VALID, AR_READY;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              R_VALID, R_READY;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              AW_VALID, AW_READY;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              W_VALID, W_READY;
  logic [DATA_W-1:0] W_DATA;
  logic              B_VALID, B_READY;
  logic [1:0]        B_RESP;
  logic [2:0]        dbgState;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .err(err), .rdata(rdata),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY),
    .dbgState(dbgState)
  );

  // ---------------- scoreboard / counters ----------------
  int nChecks = 0;
  int nErrors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DRAM responder ----------------
  int arDelay = 0, awDelay = 0, wDelay = 0, rDelay = 0, bDelay = 0;
  logic [1:0]        rResp = 2'b00, bResp = 2'b00;
  logic [DATA_W-1:0] rDataBase = '0;
  logic              tagAddr = 1'b0;   // xor the read address into R_DATA
  logic [ADDR_W-1:0] arAddrL = '0;

  initial begin
    int arCnt, awCnt, wCnt, rCnt, bCnt;
    arCnt = 0; awCnt = 0; wCnt = 0; rCnt = 0; bCnt = 0;
    AR_READY = 0; AW_READY = 0; W_READY = 0;
    R_VALID = 0; R_DATA = '0; R_RESP = 0; B_VALID = 0; B_RESP = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arCnt = 0; awCnt = 0; wCnt = 0; rCnt = 0; bCnt = 0;
        AR_READY = 0; AW_READY = 0; W_READY = 0;
        R_VALID = 0; R_DATA = '0; R_RESP = 0; B_VALID = 0; B_RESP = 0;
      end else begin
        if (AR_VALID) begin arCnt++; arAddrL = AR_ADDR; end else arCnt = 0;
        AR_READY = AR_VALID && (arCnt > arDelay);
        if (AW_VALID) awCnt++; else awCnt = 0;
        AW_READY = AW_VALID && (awCnt > awDelay);
        if (W_VALID) wCnt++; else wCnt = 0;
        W_READY = W_VALID && (wCnt > wDelay);
        if (R_READY) rCnt++; else rCnt = 0;
        R_VALID = R_READY && (rCnt > rDelay);
        R_DATA  = R_VALID ? (rDataBase ^ (tagAddr ? {47'b0, arAddrL} : 64'b0)) : '0;
        R_RESP  = R_VALID ? rResp : 2'b00;
        if (B_READY) bCnt++; else bCnt = 0;
        B_VALID = B_READY && (bCnt > bDelay);
        B_RESP  = B_VALID ? bResp : 2'b00;
      end
    end
  end

  // ---------------- transaction helper ----------------
  int arCycles, awCycles, wCycles;
  logic busBad, lastBReady;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expWdata;

  // Waits (at most 50 cycles) for a done pulse, sampling 1 time unit after
  // each rising edge. cyc counts cycles from the first edge to the done cycle.
  task automatic waitDone(input string tag, output int cyc, output logic [1:0] d,
                          output logic e, output logic [63:0] rd);
    cyc = 0; d = 2'b00; e = 1'b0; rd = '0;
    arCycles = 0; awCycles = 0; wCycles = 0; busBad = 1'b0; lastBReady = 1'b0;
    while (cyc < 50 && d == 2'b00) begin
      @(posedge clk); #1;
      cyc++;
      if (done != 2'b00) begin
        d = done; e = err; rd = rdata;
      end else begin
        if (AR_VALID) begin arCycles++; if (AR_ADDR !== expAddr) busBad = 1'b1; end
        else if (AR_ADDR !== '0) busBad = 1'b1;
        if (AW_VALID) begin awCycles++; if (AW_ADDR !== expAddr) busBad = 1'b1; end
        else if (AW_ADDR !== '0) busBad = 1'b1;
        if (W_VALID) begin wCycles++; if (W_DATA !== expWdata) busBad = 1'b1; end
        else if (W_DATA !== '0) busBad = 1'b1;
        lastBReady = B_READY;
      end
    end
    check({tag, "_timeout"}, 64'(d == 2'b00), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [1:0] d;
    logic e;
    logic [63:0] rd;
    logic [1:0] ex;
    logic sawW;

    // Reset state
    #12;
    check("rst_state", 64'(dbgState), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valids", 64'({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, err}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single aligned read, zero wait
    rDataBase = 64'hDEAD_BEEF_0123_4567; tagAddr = 1'b0;
    addr0 = 17'h10000; we = 2'b00; expAddr = 17'h10000; expWdata = '0;
    req = 2'b01;
    waitDone("rd", cyc, d, e, rd);
    req = 2'b00;
    check("rd_latency", 64'(cyc), 64'd3);
    check("rd_done", 64'(d), 64'b01);
    check("rd_data", rd, 64'hDEAD_BEEF_0123_4567);
    check("rd_err", 64'(e), 64'd0);
    check("rd_ar_cycles", 64'(arCycles), 64'd1);
    check("rd_bus", 64'(busBad), 64'd0);
    @(posedge clk); #1;
    check("rd_done_pulse", 64'(done), 64'd0);

    // Write from requester 1 with AW/W stalls
    awDelay = 3; wDelay = 2;
    addr1 = 17'h10008; wdata1 = 64'h1; we = 2'b10; expAddr = 17'h10008; expWdata = 64'h1;
    req = 2'b10;
    waitDone("wr", cyc, d, e, rd);
    req = 2'b00; we = 2'b00;
    awDelay = 0; wDelay = 0;
    check("wr_latency", 64'(cyc), 64'd9);
    check("wr_done", 64'(d), 64'b10);
    check("wr_err", 64'(e), 64'd0);
    check("wr_aw_cycles", 64'(awCycles), 64'd4);
    check("wr_w_cycles", 64'(wCycles), 64'd3);
    check("wr_bus_steady", 64'(busBad), 64'd0);
    check("wr_done_after_b", 64'(lastBReady), 64'd1);
    @(posedge clk); #1;

    // Contention from reset: grants must alternate 0,1,0,1
    rst = 1'b1;
    tagAddr = 1'b1; rDataBase = 64'hA5A5_0000_0000_0000;
    addr0 = 17'h00100; addr1 = 17'h00208; we = 2'b00; req = 2'b11;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex = exp_q.pop_front();
      expAddr = (ex == 2'b01) ? addr0 : addr1;
      waitDone($sformatf("cont%0d", i), cyc, d, e, rd);
      check($sformatf("cont%0d_done", i), 64'(d), 64'(ex));
      check($sformatf("cont%0d_data", i), rd, rDataBase ^ {47'b0, expAddr});
      check($sformatf("cont%0d_latency", i), 64'(cyc), 64'd3);
      if (i < 3) begin
        req = req & ~ex;
        @(posedge clk); #1;
        req = req | ex;
      end else begin
        req = 2'b00;
      end
    end
    @(posedge clk); #1;

    // Misaligned read: immediate error, no bus activity
    addr0 = 17'h10003; expAddr = 17'h10003; req = 2'b01;
    waitDone("mis", cyc, d, e, rd);
    req = 2'b00;
    check("mis_latency", 64'(cyc), 64'd1);
    check("mis_done", 64'(d), 64'b01);
    check("mis_err", 64'(e), 64'd1);
    check("mis_no_bus", 64'(arCycles + awCycles + wCycles), 64'd0);
    @(posedge clk); #1;

    // Read error response
    rResp = 2'b10; addr1 = 17'h10010; expAddr = 17'h10010; req = 2'b10;
    waitDone("rerr", cyc, d, e, rd);
    req = 2'b00; rResp = 2'b00;
    check("rerr_done", 64'(d), 64'b10);
    check("rerr_err", 64'(e), 64'd1);
    @(posedge clk); #1;

    // Write error response
    bResp = 2'b01; addr0 = 17'h10018; wdata0 = 64'h55; we = 2'b01;
    expAddr = 17'h10018; expWdata = 64'h55; req = 2'b01;
    waitDone("berr", cyc, d, e, rd);
    req = 2'b00; bResp = 2'b00;
    check("berr_done", 64'(d), 64'b01);
    check("berr_err", 64'(e), 64'd1);
    @(posedge clk); #1;

    // Async reset while in W (requester 0 was granted last before reset)
    wDelay = 5; addr0 = 17'h10020; wdata0 = 64'hCAFE_F00D_1234_5678; we = 2'b01;
    req = 2'b01; sawW = 1'b0;
    for (int i = 0; i < 20 && !sawW; i++) begin
      @(posedge clk); #1;
      sawW = W_VALID;
    end
    check("arst_reached_w", 64'(sawW), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_w", 64'({W_VALID, AW_VALID, AR_VALID, R_READY, B_READY}), 64'd0);
    check("arst_wdata", W_DATA, 64'd0);
    check("arst_addr", 64'({AR_ADDR, AW_ADDR}), 64'd0);
    check("arst_done_err", 64'({done, err}), 64'd0);
    check("arst_rdata", rdata, 64'd0);
    check("arst_state", 64'(dbgState), 64'd0);
    wDelay = 0; we = 2'b00; addr0 = 17'h10020; addr1 = 17'h10028; req = 2'b11;
    @(negedge clk); rst = 1'b0;
    expAddr = addr0;
    waitDone("arst_first", cyc, d, e, rd);
    check("arst_first_done", 64'(d), 64'b01);
    check("arst_first_data", rd, rDataBase ^ {47'b0, addr0});
    req = 2'b10;
    expAddr = addr1;
    waitDone("arst_second", cyc, d, e, rd);
    check("arst_second_done", 64'(d), 64'b10);
    req = 2'b00;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", nErrors);
    $fatal(1, "watchdog expired");
  end

endmodule
